// File: rtl/elastic_pipeline.sv
// Elastic delay line: DEPTH register stages with per-stage valid bits, valid/ready
// backpressure with bubble collapsing and synchronous flush. Optional macro: ELASTIC_PIPE_OCC_EN.
module elastic_pipeline #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int RESET_DATA = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef ELASTIC_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  // Handshake: a beat moves on a port in any cycle where valid and ready are both
  // high at the rising edge; valid never waits for ready, ready may follow out_ready.

  logic [DEPTH-1:0] v_q, v_d, v_n, adv;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic             all_full;

  // A stage advances when any stage at or after it is empty, or the consumer takes the head.
  always_comb begin
    all_full = 1'b1;
    adv      = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      all_full = all_full & v_q[i];
      adv[i]   = out_ready | ~all_full;
    end
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (adv[0]) begin
      v_d[0] = in_valid;
      d_d[0] = in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (adv[i]) begin
        v_d[i] = v_q[i-1];
        d_d[i] = d_q[i-1];
      end
    end
    v_n = (!rst || flush) ? '0 : v_d;
  end

  always_ff @(posedge clk) begin
    v_q <= v_n;
  end

  if (RESET_DATA != 0) begin : g_data_rst
    always_ff @(posedge clk) begin
      if (!rst || flush) begin
        for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
      end else begin
        d_q <= d_d;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk) begin
      if (rst && !flush) d_q <= d_d;
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = v_q[DEPTH-1] & ~flush;
  assign out_data  = d_q[DEPTH-1];

`ifdef ELASTIC_PIPE_OCC_EN
  localparam int OCC_W = $clog2(DEPTH + 1);
  logic [OCC_W-1:0] occ_d, occ_q;

  // Counted from next-state valids so the registered count lines up with v_q.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) occ_d = occ_d + OCC_W'(v_n[i]);
  end

  always_ff @(posedge clk) begin
    occ_q <= occ_d;
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_elastic_pipeline.sv
// Bench for elastic_pipeline: three instances (DEPTH 4, 1, 7) checked every cycle
// against a beat-timing model; directed scenarios on the DEPTH=4 instance.
module tb_elastic_pipeline;

  localparam int W = 8;
  localparam int N = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst       [N];
  logic         flush     [N];
  logic         in_valid  [N];
  logic         in_ready  [N];
  logic [W-1:0] in_data   [N];
  logic         out_valid [N];
  logic         out_ready [N];
  logic [W-1:0] out_data  [N];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- DUTs + per-instance model ----------------
  for (genvar k = 0; k < N; k++) begin : g_inst
    localparam int D  = (k == 0) ? 4 : (k == 1) ? 1 : 7;
    localparam int RD = (k == 2) ? 0 : 1;
`ifdef ELASTIC_PIPE_OCC_EN
    logic [$clog2(D+1)-1:0] occupancy;
`endif

    elastic_pipeline #(.WIDTH(W), .DEPTH(D), .RESET_DATA(RD)) u_dut (
      .clk       (clk),
      .rst       (rst[k]),
      .flush     (flush[k]),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .in_data   (in_data[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k])
`ifdef ELASTIC_PIPE_OCC_EN
      ,
      .occupancy (occupancy)
`endif
    );

    // Model: beats in flight in order with their acceptance cycle. A beat reaches the
    // output at max(accept + D, previous beat's consume cycle + 1).
    logic [W-1:0] exp_q[$];
    int           acc_cyc_q[$];
    int           cyc     = 0;
    int           last_c  = -1000;
    int           ready_t = 0;
    bit           started = 0;
    bit           m_ov    = 0;
    bit           m_ir    = 0;

    always @(negedge clk) begin
      if (started) begin
        m_ov = 0;
        if (exp_q.size() > 0) begin
          ready_t = acc_cyc_q[0] + D;
          if (last_c + 1 > ready_t) ready_t = last_c + 1;
          m_ov = !flush[k] && (cyc >= ready_t);
        end
        m_ir = !flush[k] && (out_ready[k] || exp_q.size() < D);
        check($sformatf("in_ready[%0d]", k), 32'(in_ready[k]), 32'(m_ir));
        check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(m_ov));
        if (m_ov) check($sformatf("out_data[%0d]", k), 32'(out_data[k]), 32'(exp_q[0]));
`ifdef ELASTIC_PIPE_OCC_EN
        check($sformatf("occupancy[%0d]", k), 32'(occupancy), 32'(exp_q.size()));
`endif
      end
    end

    always @(posedge clk) begin
      if (!rst[k]) begin
        exp_q.delete();
        acc_cyc_q.delete();
        last_c  = -1000;
        started = 1;
      end else if (started) begin
        if (flush[k]) begin
          exp_q.delete();
          acc_cyc_q.delete();
        end else begin
          if (m_ov && out_ready[k]) begin
            void'(exp_q.pop_front());
            void'(acc_cyc_q.pop_front());
            last_c = cyc;
          end
          if (in_valid[k] && m_ir) begin
            exp_q.push_back(in_data[k]);
            acc_cyc_q.push_back(cyc);
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- transfer recorder for instance 0 ----------------
  int           tcyc = 0;
  logic [W-1:0] acc_q[$];
  logic [W-1:0] out_q[$];
  int           acc_t[$];
  int           out_t[$];

  always @(posedge clk) tcyc++;

  always @(negedge clk) begin
    if (rst[0]) begin
      if (in_valid[0] && in_ready[0]) begin acc_q.push_back(in_data[0]); acc_t.push_back(tcyc); end
      if (out_valid[0] && out_ready[0]) begin out_q.push_back(out_data[0]); out_t.push_back(tcyc); end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_rec();
    acc_q.delete(); out_q.delete(); acc_t.delete(); out_t.delete();
  endtask

  task automatic send0(input logic [W-1:0] data);
    bit ok = 0;
    in_valid[0] = 1'b1;
    in_data[0]  = data;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (in_ready[0] === 1'b1);
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_outs(input string name, input int n, input logic [W-1:0] base);
    check({name, "_count"}, 32'(out_q.size()), 32'(n));
    for (int i = 0; i < n && i < out_q.size(); i++)
      check($sformatf("%s_data%0d", name, i), 32'(out_q[i]), 32'(base + W'(i)));
  endtask

  task automatic directed();
    // Streaming
    clear_rec();
    out_ready[0] = 1'b1;
    for (int i = 0; i < 8; i++) send0(8'h10 + W'(i));
    tick(8);
    check_outs("stream", 8, 8'h10);
    for (int i = 0; i < 8 && i < out_t.size() && i < acc_t.size(); i++) begin
      check($sformatf("stream_lat%0d", i), 32'(out_t[i] - acc_t[i]), 32'd4);
      check($sformatf("stream_rate%0d", i), 32'(acc_t[i] - acc_t[0]), 32'(i));
    end

    // Backpressure fill
    clear_rec();
    out_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) send0(8'hA0 + W'(i));
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hA4;
    @(negedge clk);
    check("bp_in_ready_low", 32'(in_ready[0]), 32'd0);
    @(posedge clk); #1;
    tick(3);
    check("bp_accepted", 32'(acc_q.size()), 32'd4);
    out_ready[0] = 1'b1;
    send0(8'hA4);
    send0(8'hA5);
    tick(8);
    check_outs("bp", 6, 8'hA0);

    // Bubble collapse
    clear_rec();
    out_ready[0] = 1'b0;
    send0(8'h01);
    tick(2);
    send0(8'h02);
    tick(6);
    @(negedge clk);
    check("bubble_head_valid", 32'(out_valid[0]), 32'd1);
    check("bubble_head_data", 32'(out_data[0]), 32'h01);
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    tick(4);
    check_outs("bubble", 2, 8'h01);
    if (out_t.size() >= 2) check("bubble_b2b", 32'(out_t[1] - out_t[0]), 32'd1);

    // Flush with beats in flight
    clear_rec();
    send0(8'h31); send0(8'h32); send0(8'h33);
    flush[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 8'h34;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready[0]), 32'd0);
    check("flush_out_valid", 32'(out_valid[0]), 32'd0);
    @(posedge clk); #1;
    flush[0] = 1'b0; in_valid[0] = 1'b0;
    @(negedge clk);
    check("post_flush_out_valid", 32'(out_valid[0]), 32'd0);
`ifdef ELASTIC_PIPE_OCC_EN
    check("post_flush_occ", 32'(g_inst[0].occupancy), 32'd0);
`endif
    @(posedge clk); #1;
    tick(8);
    check("flush_no_leak", 32'(out_q.size()), 32'd0);
    check("flush_accepted", 32'(acc_q.size()), 32'd3);

    // Reset mid-stream
    for (int i = 0; i < 6; i++) send0(8'h40 + W'(i));
    rst[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = 8'h46;
    tick(1);
    rst[0] = 1'b1; in_valid[0] = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_mid_out_data", 32'(out_data[0]), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;
    clear_rec();
    send0(8'h55);
    tick(6);
    check_outs("rst_new", 1, 8'h55);
    if (out_t.size() >= 1 && acc_t.size() >= 1)
      check("rst_new_lat", 32'(out_t[0] - acc_t[0]), 32'd4);
  endtask

  task automatic rand_run(input int k);
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      rst[k]      = ($urandom_range(0, 149) != 0);
      flush[k]    = ($urandom_range(0, 39) == 0);
      in_valid[k] = ($urandom_range(0, 3) != 0);
      in_data[k]  = W'($urandom);
      if (n < 200)      out_ready[k] = ($urandom_range(0, 3) != 0);
      else if (n < 400) out_ready[k] = ($urandom_range(0, 3) == 0);
      else              out_ready[k] = ($urandom_range(0, 1) == 0);
    end
    @(posedge clk); #1;
    rst[k] = 1'b1; flush[k] = 1'b0; in_valid[k] = 1'b0; out_ready[k] = 1'b1;
    tick(12);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b0; flush[k] = 1'b0; in_valid[k] = 1'b0;
      in_data[k] = '0; out_ready[k] = 1'b0;
    end
    tick(2);
    for (int k = 0; k < N; k++) rst[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("reset_out_valid%0d", k), 32'(out_valid[k]), 32'd0);
      check($sformatf("reset_in_ready%0d", k), 32'(in_ready[k]), 32'd1);
    end
    check("reset_out_data0", 32'(out_data[0]), 32'd0);
    check("reset_out_data1", 32'(out_data[1]), 32'd0);
    @(posedge clk); #1;
    fork
      directed();
      rand_run(1);
      rand_run(2);
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
